// File: rtl/instr_field_pipe_pkg.sv
// Shared constants for the instruction field pipe: MIPS field bit positions,
// opcode values used for classification, and the class encodings.
package instr_field_pipe_pkg;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM16_MSB  = 15;
  localparam int IMM16_LSB  = 0;
  localparam int IMM26_MSB  = 25;
  localparam int IMM26_LSB  = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  typedef enum logic [1:0] {
    CLASS_R = 2'd0,
    CLASS_J = 2'd1,
    CLASS_I = 2'd2
  } instr_class_e;

  function automatic instr_class_e classify(input logic [5:0] opcode);
    if (opcode == OP_RTYPE)                      return CLASS_R;
    else if (opcode == OP_J || opcode == OP_JAL) return CLASS_J;
    else                                         return CLASS_I;
  endfunction

endpackage

// File: rtl/instr_field_fifo.sv
// Storage for pre-decoded instruction entries: circular buffer with
// pointers and an occupancy count. Data out is zero whenever empty.
module instr_field_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               out_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Entry write; a flush in the same cycle makes the write irrelevant since
  // the pointers are cleared, but it is gated anyway to keep intent clear.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= in_data;
  end

  // Pointer and count update; flush overrides any same-cycle push or pop.
  // DEPTH is a power of two so the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_field_pipe.sv
// Instruction field pipe: splits a MIPS word into its fields, extends imm16
// and forms the J-type target at push time, then buffers the decoded entry.
// Optional feature: define INSTR_CLASS_EN to add the out_class port.
module instr_field_pipe #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [PC_W-1:0]        in_pc,
  input  logic                   in_sext,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [5:0]             out_opcode,
  output logic [4:0]             out_rs,
  output logic [4:0]             out_rt,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_shamt,
  output logic [5:0]             out_funct,
  output logic [31:0]            out_imm32,
  output logic [PC_W-1:0]        out_jtarget,
  output logic [PC_W-1:0]        out_pc,
`ifdef INSTR_CLASS_EN
  output logic [1:0]             out_class,
`endif
  output logic [$clog2(DEPTH):0] count
);

  import instr_field_pipe_pkg::*;

  typedef struct packed {
`ifdef INSTR_CLASS_EN
    logic [1:0]      cls;
`endif
    logic [5:0]      opcode;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [5:0]      funct;
    logic [31:0]     imm32;
    logic [PC_W-1:0] jtarget;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t              push_entry;
  entry_t              head;
  logic [PC_W-29:0]    pc4_hi;

  // Upper bits of pc+4: only bits [27:2] can carry into them, and the add
  // wraps naturally at PC_W bits.
  assign pc4_hi = in_pc[PC_W-1:28] + (PC_W-28)'(&in_pc[27:2]);

  // Field extraction and extension happen before storage.
  always_comb begin
    push_entry         = '0;
`ifdef INSTR_CLASS_EN
    push_entry.cls     = classify(in_instr[OPCODE_MSB:OPCODE_LSB]);
`endif
    push_entry.opcode  = in_instr[OPCODE_MSB:OPCODE_LSB];
    push_entry.rs      = in_instr[RS_MSB:RS_LSB];
    push_entry.rt      = in_instr[RT_MSB:RT_LSB];
    push_entry.rd      = in_instr[RD_MSB:RD_LSB];
    push_entry.shamt   = in_instr[SHAMT_MSB:SHAMT_LSB];
    push_entry.funct   = in_instr[FUNCT_MSB:FUNCT_LSB];
    push_entry.imm32   = {{16{in_instr[IMM16_MSB] & in_sext}}, in_instr[IMM16_MSB:IMM16_LSB]};
    push_entry.jtarget = {pc4_hi, in_instr[IMM26_MSB:IMM26_LSB], 2'b00};
    push_entry.pc      = in_pc;
  end

  instr_field_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (push_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head),
    .count     (count)
  );

  // The fifo already zeroes its data when empty, so these are plain wires.
  assign out_opcode  = head.opcode;
  assign out_rs      = head.rs;
  assign out_rt      = head.rt;
  assign out_rd      = head.rd;
  assign out_shamt   = head.shamt;
  assign out_funct   = head.funct;
  assign out_imm32   = head.imm32;
  assign out_jtarget = head.jtarget;
  assign out_pc      = head.pc;
`ifdef INSTR_CLASS_EN
  assign out_class   = head.cls;
`endif

endmodule

// File: tb/tb_instr_field_pipe.sv
// Bench for instr_field_pipe: a DEPTH=2 and a DEPTH=4 instance share the
// same stimulus; each has its own expected-entry queue.
module tb_instr_field_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        in_sext = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        ir2, ov2, ir4, ov4;
  logic [5:0]  op2, fn2, op4, fn4;
  logic [4:0]  rs2, rt2, rd2, sh2, rs4, rt4, rd4, sh4;
  logic [31:0] im2, jt2, pc2, im4, jt4, pc4;
  logic [1:0]  c2;
  logic [2:0]  c4;
`ifdef INSTR_CLASS_EN
  logic [1:0]  cl2, cl4;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        sext;
  } ent_t;

  ent_t q2[$];
  ent_t q4[$];

  always #5 clk = ~clk;

  instr_field_pipe #(.PC_W(32), .DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
    .in_instr(in_instr), .in_pc(in_pc), .in_sext(in_sext), .flush(flush),
    .out_valid(ov2), .out_ready(out_ready), .out_opcode(op2), .out_rs(rs2),
    .out_rt(rt2), .out_rd(rd2), .out_shamt(sh2), .out_funct(fn2),
    .out_imm32(im2), .out_jtarget(jt2), .out_pc(pc2),
`ifdef INSTR_CLASS_EN
    .out_class(cl2),
`endif
    .count(c2)
  );

  instr_field_pipe #(.PC_W(32), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4),
    .in_instr(in_instr), .in_pc(in_pc), .in_sext(in_sext), .flush(flush),
    .out_valid(ov4), .out_ready(out_ready), .out_opcode(op4), .out_rs(rs4),
    .out_rt(rt4), .out_rd(rd4), .out_shamt(sh4), .out_funct(fn4),
    .out_imm32(im4), .out_jtarget(jt4), .out_pc(pc4),
`ifdef INSTR_CLASS_EN
    .out_class(cl4),
`endif
    .count(c4)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference decode: opcode..funct laid end to end is the word itself.
  function automatic logic [127:0] model_vec(input ent_t e);
    logic [31:0] imm, jt;
    imm = e.sext ? {{16{e.instr[15]}}, e.instr[15:0]} : {16'h0000, e.instr[15:0]};
    jt  = ((e.pc + 32'd4) & 32'hF000_0000) | {4'h0, e.instr[25:0], 2'b00};
    return {e.instr, imm, jt, e.pc};
  endfunction

  function automatic logic [1:0] model_class(input ent_t e);
    case (e.instr[31:26])
      6'd0:       return 2'd0;
      6'd2, 6'd3: return 2'd1;
      default:    return 2'd2;
    endcase
  endfunction

  task automatic check_all(input string tag);
    logic [127:0] e2, e4;
    e2 = (q2.size() != 0) ? model_vec(q2[0]) : '0;
    e4 = (q4.size() != 0) ? model_vec(q4[0]) : '0;
    chk({tag, " d2.count"}, 128'(c2), 128'(q2.size()));
    chk({tag, " d4.count"}, 128'(c4), 128'(q4.size()));
    chk({tag, " d2.out_valid"}, 128'(ov2), 128'(q2.size() != 0));
    chk({tag, " d4.out_valid"}, 128'(ov4), 128'(q4.size() != 0));
    chk({tag, " d2.data"}, {op2, rs2, rt2, rd2, sh2, fn2, im2, jt2, pc2}, e2);
    chk({tag, " d4.data"}, {op4, rs4, rt4, rd4, sh4, fn4, im4, jt4, pc4}, e4);
`ifdef INSTR_CLASS_EN
    chk({tag, " d2.class"}, 128'(cl2), 128'((q2.size() != 0) ? model_class(q2[0]) : 2'd0));
    chk({tag, " d4.class"}, 128'(cl4), 128'((q4.size() != 0) ? model_class(q4[0]) : 2'd0));
`endif
  endtask

  // One clock with the currently driven inputs; the model follows the same
  // handshake rules and the outputs are compared #1 after the edge.
  task automatic cyc(input string tag);
    bit   p2, p4, o2, o4;
    ent_t cur;
    chk({tag, " d2.in_ready"}, 128'(ir2), 128'(q2.size() < 2));
    chk({tag, " d4.in_ready"}, 128'(ir4), 128'(q4.size() < 4));
    cur.instr = in_instr;
    cur.pc    = in_pc;
    cur.sext  = in_sext;
    p2 = in_valid && (q2.size() < 2);
    p4 = in_valid && (q4.size() < 4);
    o2 = out_ready && (q2.size() != 0);
    o4 = out_ready && (q4.size() != 0);
    @(posedge clk);
    if (flush) begin
      q2.delete();
      q4.delete();
    end else begin
      if (o2) void'(q2.pop_front());
      if (o4) void'(q4.pop_front());
      if (p2) q2.push_back(cur);
      if (p4) q4.push_back(cur);
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] p, input logic s);
    in_valid = v;
    in_instr = w;
    in_pc    = p;
    in_sext  = s;
  endtask

  initial begin
    #3;
    check_all("reset");
    chk("reset d2.in_ready", 128'(ir2), 128'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // addi, sign-extended
    drive(1'b1, 32'h2008FFFF, 32'h0040_0000, 1'b1);
    cyc("addi_sx");
    chk("addi_sx opcode", 128'(op2), 128'(6'h08));
    chk("addi_sx rs", 128'(rs2), 128'(0));
    chk("addi_sx rt", 128'(rt2), 128'(8));
    chk("addi_sx imm32", 128'(im2), 128'(32'hFFFF_FFFF));
    chk("addi_sx count", 128'(c2), 128'(1));
    drive(1'b0, '0, '0, 1'b0);
    out_ready = 1'b1;
    cyc("addi_sx_pop");

    // same word, zero-extended
    drive(1'b1, 32'h2008FFFF, 32'h0040_0000, 1'b0);
    out_ready = 1'b0;
    cyc("addi_zx");
    chk("addi_zx imm32", 128'(im2), 128'(32'h0000_FFFF));
    drive(1'b0, '0, '0, 1'b0);
    out_ready = 1'b1;
    cyc("addi_zx_pop");

    // j with the PC in the top segment
    drive(1'b1, 32'h08100003, 32'hF000_0000, 1'b1);
    out_ready = 1'b0;
    cyc("jump");
    chk("jump jtarget", 128'(jt2), 128'(32'hF040_000C));
`ifdef INSTR_CLASS_EN
    chk("jump class", 128'(cl2), 128'(2'd1));
`endif
    drive(1'b0, '0, '0, 1'b0);
    out_ready = 1'b1;
    cyc("jump_pop");

    // fill with out_ready low: DEPTH=2 refuses the third word
    out_ready = 1'b0;
    drive(1'b1, 32'h012A4020, 32'h0000_1000, 1'b0);
    cyc("fill0");
    drive(1'b1, 32'h0C000040, 32'h0000_1004, 1'b0);
    cyc("fill1");
    chk("fill d2.in_ready_low", 128'(ir2), 128'(0));
    chk("fill d2.count_full", 128'(c2), 128'(2));
    drive(1'b1, 32'h8D09FFFC, 32'h0000_1008, 1'b1);
    cyc("fill2");
    cyc("fill_hold");
    drive(1'b0, '0, '0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc("drain");

    // streaming push and pop, pointers wrap several times
    drive(1'b1, $urandom, $urandom, 1'($urandom));
    cyc("stream_first");
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, $urandom, $urandom, 1'($urandom));
      cyc("stream");
      chk("stream d4.count", 128'(c4), 128'(1));
    end
    drive(1'b0, '0, '0, 1'b0);
    cyc("stream_drain");

    // flush wins over a simultaneous push
    out_ready = 1'b0;
    drive(1'b1, 32'h3C01ABCD, 32'h0000_2000, 1'b0);
    cyc("pre_flush0");
    drive(1'b1, 32'h0000000C, 32'h0000_2004, 1'b0);
    cyc("pre_flush1");
    flush = 1'b1;
    drive(1'b1, 32'h24420001, 32'h0000_2008, 1'b1);
    cyc("flush");
    chk("flush d2.count", 128'(c2), 128'(0));
    chk("flush d2.out_pc", 128'(pc2), 128'(0));
    flush = 1'b0;

    // reset asserted mid-stream empties at once, without a clock edge
    drive(1'b1, 32'h1000FFFF, 32'h0000_3000, 1'b1);
    cyc("pre_rst");
    drive(1'b1, 32'hAC0A0010, 32'h0000_3004, 1'b0);
    rst = 1'b1;
    #1;
    q2.delete();
    q4.delete();
    check_all("rst_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("rst_hold");
    drive(1'b1, 32'h03E00008, 32'h0000_4000, 1'b0);
    cyc("after_rst");
    drive(1'b0, '0, '0, 1'b0);
    out_ready = 1'b1;
    cyc("after_rst_pop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
